pipe_skid_buffer: RTL

- Two-entry elastic pipeline register between RISC-V core stages, e.g. fetch→decode or decode→execute.
- Upstream stage writes into it with a valid/ready handshake. Downstream stage reads from it with the same handshake.
- Registers in_ready (function of state only) so backpressure never forms a combinational path upstream.
- Sustains one transfer per cycle with 1-cycle latency. Supports a pipeline flush for branch/jump redirect.

---
 rtl/pipe_pkg.sv | 12 +
 rtl/skid_data_slot.sv | 20 ++
 rtl/pipe_skid_buffer.sv | 111 +++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the two-entry elastic pipeline register.
package pipe_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

endpackage

// File: rtl/skid_data_slot.sv
// N-bit data register with load enable and asynchronous active-low clear.
module skid_data_slot #(
  parameter int unsigned N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ld,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (ld) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_skid_buffer.sv
// Two-entry skid buffer between pipeline stages; in_ready depends on state only,
// so upstream backpressure never sees a combinational path from out_ready.
module pipe_skid_buffer
  import pipe_pkg::*;
#(
  parameter int unsigned N = XLEN
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic [1:0]   occupancy
);

  state_t       state;
  state_t       state_n;
  logic         in_fire;
  logic         out_fire;
  logic         main_ld;
  logic         skid_ld;
  logic [N-1:0] main_d;
  logic [N-1:0] skid_d;
  logic [N-1:0] main_q;
  logic [N-1:0] skid_q;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_EMPTY;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    main_ld = 1'b0;
    skid_ld = 1'b0;
    main_d  = in_data;
    skid_d  = in_data;
    unique case (state)
      ST_EMPTY: begin
        if (in_fire) begin
          state_n = ST_ONE;
          main_ld = 1'b1;
        end
      end
      ST_ONE: begin
        if (in_fire && out_fire) begin
          main_ld = 1'b1;
        end else if (in_fire) begin
          state_n = ST_FULL;
          skid_ld = 1'b1;
        end else if (out_fire) begin
          state_n = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (out_fire) begin
          state_n = ST_ONE;
          main_ld = 1'b1;
          main_d  = skid_q;
          skid_ld = 1'b1;
          skid_d  = '0;
        end
      end
      default: state_n = ST_EMPTY;
    endcase
    // Flush overrides every transition; any word accepted this cycle is dropped.
    if (flush) begin
      state_n = ST_EMPTY;
      main_ld = 1'b0;
      skid_ld = 1'b0;
    end
  end

  always_comb begin
    in_ready  = (state != ST_FULL);
    out_valid = (state != ST_EMPTY);
    out_data  = main_q;
    case (state)
      ST_ONE:  occupancy = 2'd1;
      ST_FULL: occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

  skid_data_slot #(.N(N)) u_main (
    .clk   (clk),
    .rst_n (rst),
    .ld    (main_ld),
    .d     (main_d),
    .q     (main_q)
  );

  skid_data_slot #(.N(N)) u_skid (
    .clk   (clk),
    .rst_n (rst),
    .ld    (skid_ld),
    .d     (skid_d),
    .q     (skid_q)
  );

endmodule
